// File: rtl/upstream_pkg.sv
// Shared definitions for the upstream cache memory interface: request/response
// bundles, line geometry and the responder state encoding.
`default_nettype none

package upstream_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_line_ram.sv
// Line store for the responder: synchronous read into an output register that
// returns to zero whenever no read is being performed.
`default_nettype none

module mem_line_ram
  import upstream_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int IDX_W  = 10,
  parameter int DEPTH  = 2**IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Contents survive reset on purpose: preloaded lines must outlive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/upstream_mem_responder.sv
// Backing memory at the far end of the upstream cache's mem_req/mem_data link:
// one line request at a time, answered after a fixed read or write latency.
`default_nettype none

module upstream_mem_responder
  import upstream_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 10,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  output logic [LINE_W-1:0] mem_data_data,
  output logic              mem_data_ready,
  output logic              mem_err,
  input  logic              init_we,
  input  logic [IDX_W-1:0]  init_idx,
  input  logic [LINE_W-1:0] init_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;
  localparam logic [1:0] ST_GAP  = GAP;

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_CW  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [LAT_CW-1:0] RD_LOAD = LAT_CW'(RD_LAT - 1);
  localparam logic [LAT_CW-1:0] WR_LOAD = LAT_CW'(WR_LAT - 1);

  logic [1:0]        state;
  logic [LAT_CW-1:0] lat_cnt;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;
  logic              req_rw;
  logic              req_legal;
  logic              ready_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_count_q;
  logic [CNT_W-1:0]  wr_count_q;

  logic              addr_legal;
  logic              resp_fire;
  logic              ram_re;
  logic              commit_we;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [LINE_W-1:0] ram_wdata;

  // A legal line address has no bits above the index field and no byte offset.
  assign addr_legal = (mem_req_addr[ADDR_W-1:IDX_W+4] == '0) &&
                      (mem_req_addr[3:0] == 4'd0);

  assign resp_fire = (state == ST_BUSY) && (lat_cnt == '0);
  assign ram_re    = resp_fire && !req_rw && req_legal;
  assign commit_we = (state == ST_RESP) && req_rw && req_legal && !rst;

  // One write port: a committing request write takes priority over the backdoor.
  always_comb begin
    ram_we    = commit_we || init_we;
    ram_waddr = init_idx;
    ram_wdata = init_data;
    if (commit_we) begin
      ram_waddr = req_idx;
      ram_wdata = req_data;
    end
  end

  mem_line_ram #(
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W),
    .DEPTH  (2**IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (req_idx),
    .rdata (mem_data_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      req_idx    <= '0;
      req_data   <= '0;
      req_rw     <= 1'b0;
      req_legal  <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_req_valid) begin
            req_idx   <= mem_req_addr[IDX_W+3:4];
            req_data  <= mem_req_data;
            req_rw    <= mem_req_rw;
            req_legal <= addr_legal;
            lat_cnt   <= mem_req_rw ? WR_LOAD : RD_LOAD;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt == '0) begin
            state   <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= !req_legal;
            // Counters update with the pulse so the cache sees them in step.
            if (req_legal && !req_rw && (rd_count_q != '1)) begin
              rd_count_q <= rd_count_q + 1'b1;
            end
            if (req_legal && req_rw && (wr_count_q != '1)) begin
              wr_count_q <= wr_count_q + 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_GAP;
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_data_ready = ready_q;
  assign mem_err        = err_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_upstream_mem_responder.sv
// Scoreboard bench for upstream_mem_responder: stimulus queues expected responses,
// a negedge monitor pops and compares each ready pulse.
`default_nettype none

module tb_upstream_mem_responder;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 10;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_req_addr = '0;
  logic [LINE_W-1:0] mem_req_data = '0;
  logic              mem_req_rw = 1'b0;
  logic              mem_req_valid = 1'b0;
  logic [LINE_W-1:0] mem_data_data;
  logic              mem_data_ready;
  logic              mem_err;
  logic              init_we = 1'b0;
  logic [IDX_W-1:0]  init_idx = '0;
  logic [LINE_W-1:0] init_data = '0;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  upstream_mem_responder #(
    .LINE_W (LINE_W), .ADDR_W (ADDR_W), .IDX_W (IDX_W),
    .RD_LAT (RD_LAT), .WR_LAT (WR_LAT), .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_rw     (mem_req_rw),
    .mem_req_valid  (mem_req_valid),
    .mem_data_data  (mem_data_data),
    .mem_data_ready (mem_data_ready),
    .mem_err        (mem_err),
    .init_we        (init_we),
    .init_idx       (init_idx),
    .init_data      (init_data),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LINE_W-1:0] data;
    logic              err;
    int                cyc;
    logic [CNT_W-1:0]  rd;
    logic [CNT_W-1:0]  wr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  logic [CNT_W-1:0] exp_rd = '0;
  logic [CNT_W-1:0] exp_wr = '0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_data_ready) begin
        n_resp++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("resp_cycle", 128'(cyc), 128'(e.cyc));
          check("resp_data", mem_data_data, e.data);
          check("resp_err", 128'(mem_err), 128'(e.err));
          check("resp_rd_count", 128'(rd_count), 128'(e.rd));
          check("resp_wr_count", 128'(wr_count), 128'(e.wr));
        end
      end else begin
        check("idle_data_zero", mem_data_data, '0);
        check("idle_err_zero", 128'(mem_err), '0);
      end
    end
  end

  task automatic wait_resp(input int start);
    int k = 0;
    while (n_resp == start && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_resp == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no ready in 50 cycles expected a response (cycle %0d)", cyc);
    end
  endtask

  task automatic do_init(input logic [IDX_W-1:0] idx, input logic [LINE_W-1:0] d);
    @(negedge clk);
    init_we = 1'b1; init_idx = idx; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                        input logic w, input logic [LINE_W-1:0] ed, input logic ee);
    exp_t e;
    int start;
    @(negedge clk);
    mem_req_addr = a; mem_req_data = d; mem_req_rw = w; mem_req_valid = 1'b1;
    @(negedge clk);
    mem_req_valid = 1'b0;
    if (!ee) begin
      if (w) exp_wr = sat(exp_wr);
      else   exp_rd = sat(exp_rd);
    end
    e.data = ed; e.err = ee; e.cyc = cyc + (w ? WR_LAT : RD_LAT);
    e.rd = exp_rd; e.wr = exp_wr;
    sb.push_back(e);
    start = n_resp;
    wait_resp(start);
    @(negedge clk);
  endtask

  logic [LINE_W-1:0] t4d [3];

  initial begin
    exp_t e;
    int acc;
    int start;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(mem_data_ready), '0);
    check("rst_err", 128'(mem_err), '0);
    check("rst_data", mem_data_data, '0);
    check("rst_rd_count", 128'(rd_count), '0);
    check("rst_wr_count", 128'(wr_count), '0);
    rst = 1'b0;

    // 1: preload then read back after RD_LAT
    do_init(10'd5, 128'h0000_01F4_0000_0064);
    do_req(32'h50, '0, 1'b0, 128'h0000_01F4_0000_0064, 1'b0);

    // 2: write then read back
    do_req(32'h50, 128'hABCD, 1'b1, '0, 1'b0);
    do_req(32'h50, '0, 1'b0, 128'hABCD, 1'b0);

    // 3: illegal read (upper bits) and illegal write (byte offset) are dropped
    do_req(32'h0001_0050, '0, 1'b0, '0, 1'b1);
    do_req(32'h54, 128'h1111, 1'b1, '0, 1'b1);
    do_req(32'h50, '0, 1'b0, 128'hABCD, 1'b0);

    // 4: valid held high over three reads; pulses separated by RD_LAT+2 non-ready cycles
    t4d[0] = 128'h1111_0001; t4d[1] = 128'h2222_0002; t4d[2] = 128'h3333_0003;
    do_init(10'd1, t4d[0]);
    do_init(10'd2, t4d[1]);
    do_init(10'd3, t4d[2]);
    @(negedge clk);
    mem_req_addr = 32'h10; mem_req_rw = 1'b0; mem_req_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_rd = sat(exp_rd);
      e.data = t4d[i]; e.err = 1'b0; e.cyc = acc + i * (RD_LAT + 3) + RD_LAT;
      e.rd = exp_rd; e.wr = exp_wr;
      sb.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      start = n_resp;
      wait_resp(start);
      if (i == 0)      mem_req_addr = 32'h20;
      else if (i == 1) mem_req_addr = 32'h30;
      else             mem_req_valid = 1'b0;
    end
    repeat (2) @(negedge clk);

    // 5: reset during BUSY of a write to idx 7
    do_init(10'd7, 128'h7777);
    @(negedge clk);
    mem_req_addr = 32'h70; mem_req_data = 128'hDEAD; mem_req_rw = 1'b1; mem_req_valid = 1'b1;
    @(negedge clk);
    mem_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0; exp_wr = '0;
    check("midrst_rd_count", 128'(rd_count), '0);
    check("midrst_wr_count", 128'(wr_count), '0);
    repeat (8) @(negedge clk);
    do_req(32'h70, '0, 1'b0, 128'h7777, 1'b0);

    // 6: saturate the 4-bit read counter and read once more
    for (int i = 0; i < 16; i++) begin
      do_req(32'h70, '0, 1'b0, 128'h7777, 1'b0);
    end
    check("sat_rd_count", 128'(rd_count), 128'hF);
    check("sat_wr_count", 128'(wr_count), '0);

    repeat (4) @(negedge clk);
    check("sb_drained", 128'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
